parallel_serial_framer: RTL and testbench

Parametrised successor to the 8-lane serial-to-FIFO packer. Captures a fixed-length burst from `N_LANES` serial data lines after a `start` pulse and packs it into `FIFO_WIDTH`-bit words for the readout FIFO. Each frame is bracketed by a header word and a trailer word. Words the FIFO cannot accept are dropped and counted, and the count is reported in the trailer. The block sits between the chip's serial data pins (already synchronised to `clk`) and the readout FIFO write port.

---
 rtl/parallel_serial_framer_pkg.sv | 39 +++
 rtl/parallel_serial_framer_if.sv | 28 ++
 rtl/parallel_serial_framer_lane_packer.sv | 53 +++++
 rtl/parallel_serial_framer.sv | 155 +++++++++++++++
 tb/tb_parallel_serial_framer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/parallel_serial_framer_pkg.sv
// Shared types for the parallel serial framer: FIFO word layout, word type
// codes and the framing state machine encoding.
package parallel_serial_pkg;

   localparam int PAYLOAD_W = 32;
   localparam int TAG_W     = 4;
   localparam int WORD_W    = TAG_W + PAYLOAD_W;

   typedef enum logic [1:0] {
      TYPE_DATA = 2'b00,
      TYPE_HDR  = 2'b10,
      TYPE_TRL  = 2'b11
   } word_type_e;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      CAPTURE,
      TRAILER
   } state_e;

   typedef struct packed {
      word_type_e             wtype;
      logic                   ovf;
      logic                   ign;
      logic [PAYLOAD_W-1:0]   payload;
   } fifo_word_t;

   function automatic fifo_word_t make_word(word_type_e wtype, logic ovf, logic ign,
                                            logic [PAYLOAD_W-1:0] payload);
      fifo_word_t w;
      w.wtype   = wtype;
      w.ovf     = ovf;
      w.ign     = ign;
      w.payload = payload;
      return w;
   endfunction

endpackage

// File: rtl/parallel_serial_framer_if.sv
// Lane inputs, FIFO write port and status outputs of the framer, bundled
// so the framer and its environment connect through one port.
interface parallel_serial_framer_if #(
   parameter int N_LANES   = 8,
   parameter int CNT_WIDTH = 16
);
   import parallel_serial_pkg::*;

   logic                  start;
   logic [N_LANES-1:0]    fd;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [WORD_W-1:0]     data_out;
   logic                  busy;
   logic [31:0]           frame_cnt;
   logic [CNT_WIDTH-1:0]  drop_cnt;

   modport master (
      input  start, fd, fifo_full,
      output fifo_wr_en, data_out, busy, frame_cnt, drop_cnt
   );

   modport slave (
      output start, fd, fifo_full,
      input  fifo_wr_en, data_out, busy, frame_cnt, drop_cnt
   );

endinterface

// File: rtl/parallel_serial_framer_lane_packer.sv
// Shift accumulator that packs K = 32/N_LANES lane samples into one 32-bit
// word, first sample in the MSBs; word_done marks the cycle the word completes.
module lane_packer
   import parallel_serial_pkg::*;
#(
   parameter int N_LANES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  sample_en,
   input  logic [N_LANES-1:0]    fd,
   output logic                  word_done,
   output logic [PAYLOAD_W-1:0]  word
);

   localparam int K    = PAYLOAD_W / N_LANES;
   localparam int SW   = (K > 1) ? $clog2(K) : 1;
   localparam int ACCW = PAYLOAD_W - N_LANES;

   generate
      if (K == 1) begin : g_wide
         assign word      = fd;
         assign word_done = sample_en;
      end else begin : g_shift
         logic [ACCW-1:0] acc_q;
         logic [SW-1:0]   smp_q;

         // The completed word is the held samples with the current one appended.
         assign word      = {acc_q, fd};
         assign word_done = sample_en && (smp_q == SW'(K - 1));

         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         always_ff @(posedge clk) begin
            if (rst || clear) begin
               smp_q <= '0;
            end else if (sample_en) begin
               smp_q <= word_done ? '0 : smp_q + 1'b1;
            end
         end

         // NOTE: the accumulator is pure datapath and needs no reset; stale
         // bits are shifted out before any word built from them is used.
         always_ff @(posedge clk) begin
            if (sample_en) begin
               acc_q <= word[ACCW-1:0];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/parallel_serial_framer.sv
// Captures a fixed-length burst from N_LANES serial lanes after start and
// writes header, packed data words and a trailer into the readout FIFO.
module parallel_serial_framer
   import parallel_serial_pkg::*;
#(
   parameter int N_LANES    = 8,
   parameter int FRAME_BITS = 16,
   parameter int FIFO_WIDTH = 36,
   parameter int CNT_WIDTH  = 16
) (
   input logic                       clk,
   input logic                       rst,
   parallel_serial_framer_if.master  bus
);

   localparam int               SMP_W    = $clog2(FRAME_BITS + 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(FRAME_BITS);

   state_e                 state_q, state_d;
   logic [SMP_W-1:0]       smp_q;
   logic                   valid_q;
   logic [FIFO_WIDTH-1:0]  dout_q;
   logic [31:0]            frame_cnt_q;
   logic [15:0]            frame_no_q;
   logic [15:0]            frame_drops_q;
   logic                   ign_q;
   logic [CNT_WIDTH-1:0]   drop_cnt_q;

   logic                   busy;
   logic                   accept;
   logic                   ign_set;
   logic                   smp_done;
   logic                   sample_en;
   logic                   wr_en;
   logic                   drop_now;
   logic                   trl_written;
   logic [15:0]            frame_drops_d;
   logic                   ign_d;

   logic                   word_done;
   logic [PAYLOAD_W-1:0]   word;

   lane_packer #(
      .N_LANES   (N_LANES)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .sample_en (sample_en),
      .fd        (bus.fd),
      .word_done (word_done),
      .word      (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)      state_d = HEADER;
         HEADER:                   state_d = CAPTURE;
         CAPTURE: if (smp_done)    state_d = TRAILER;
         TRAILER: if (trl_written) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // The HEADER cycle already takes the first sample; CAPTURE ends with one
   // drain cycle that presents the last data word before the trailer loads.
   always_comb begin
      busy          = (state_q != IDLE);
      accept        = (state_q == IDLE) && bus.start;
      ign_set       = busy && bus.start;
      smp_done      = (smp_q == SMP_LAST);
      sample_en     = (state_q == HEADER) || ((state_q == CAPTURE) && !smp_done);
      wr_en         = valid_q && !bus.fifo_full;
      drop_now      = valid_q && bus.fifo_full && (state_q != TRAILER);
      trl_written   = (state_q == TRAILER) && wr_en;
      frame_drops_d = (frame_drops_q == 16'hFFFF) ? frame_drops_q
                                                  : frame_drops_q + 16'(drop_now);
      ign_d         = ign_q || ign_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_q         <= '0;
         frame_cnt_q   <= '0;
         frame_no_q    <= '0;
         frame_drops_q <= '0;
         ign_q         <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         if (accept) begin
            smp_q <= '0;
         end else if (sample_en) begin
            smp_q <= smp_q + 1'b1;
         end

         if (drop_now && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end

         if (accept) begin
            frame_cnt_q   <= frame_cnt_q + 32'd1;
            frame_no_q    <= frame_cnt_q[15:0];
            frame_drops_q <= '0;
            ign_q         <= 1'b0;
         end else if (busy) begin
            frame_drops_q <= frame_drops_d;
            ign_q         <= ign_d;
         end
      end
   end

   // Output word register; the trailer folds in a drop or ignored start
   // occurring in its own load cycle, and is held until the FIFO takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         dout_q  <= make_word(TYPE_HDR, 1'b0, 1'b0, frame_cnt_q);
      end else if (word_done) begin
         valid_q <= 1'b1;
         dout_q  <= make_word(TYPE_DATA, 1'b0, 1'b0, word);
      end else if ((state_q == CAPTURE) && smp_done) begin
         valid_q <= 1'b1;
         dout_q  <= make_word(TYPE_TRL, frame_drops_d != '0, ign_d,
                              {frame_no_q, frame_drops_d});
      end else if (state_q == TRAILER) begin
         valid_q <= !trl_written;
         if (!trl_written && ign_set) begin
            dout_q[PAYLOAD_W] <= 1'b1;
         end
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign bus.fifo_wr_en = wr_en;
   assign bus.data_out   = dout_q;
   assign bus.busy       = busy;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_parallel_serial_framer.sv
// Scoreboard bench for parallel_serial_framer: each frame's expected FIFO
// writes are queued up front and matched against writes as they occur.
module tb_parallel_serial_framer;
   import parallel_serial_pkg::*;

   localparam int N_LANES    = 8;
   localparam int FRAME_BITS = 16;
   localparam int CNT_WIDTH  = 16;
   localparam int K          = 32 / N_LANES;
   localparam int NW         = FRAME_BITS * N_LANES / 32;

   typedef struct {
      int          cyc;
      logic [35:0] word;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   parallel_serial_framer_if #(.N_LANES(N_LANES), .CNT_WIDTH(CNT_WIDTH)) bus ();

   parallel_serial_framer #(
      .N_LANES    (N_LANES),
      .FRAME_BITS (FRAME_BITS),
      .FIFO_WIDTH (36),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   exp_t                  sb[$];
   int                    n_checks = 0;
   int                    n_fail   = 0;
   int                    cur_cyc  = -100;
   logic [N_LANES-1:0]    fd_tab [0:63];
   logic [31:0]           exp_fcnt = '0;
   logic [CNT_WIDTH-1:0]  exp_dcnt = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", tag, got, exp, cur_cyc, $time);
      end
   endtask

   function automatic bit in_full(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   task automatic expect_word(input int c, input logic [35:0] w, input int rst_at);
      exp_t e;
      if (rst_at == 0 || c < rst_at) begin
         e.cyc  = c;
         e.word = w;
         sb.push_back(e);
      end
   endtask

   // Every FIFO write must match the oldest expectation in data and cycle.
   always @(negedge clk) begin
      if (bus.fifo_wr_en) begin
         if (sb.size() == 0) begin
            check("spurious_wr_en", 64'(bus.fifo_wr_en), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_cycle", 64'(cur_cyc), 64'(e.cyc));
            check("wr_data", 64'(bus.data_out), 64'(e.word));
         end
      end
   end

   // mode 0: all ones, 1: walking one, other: random lanes.
   // rst_at = 0 means no reset during the frame.
   task automatic run_frame(input int mode, input int full_lo, input int full_hi,
                            input int xstart, input int rst_at);
      int          trl_cyc;
      int          last;
      int          drops;
      int          c_w;
      logic        ign;
      logic [31:0] fno;
      logic [31:0] acc;

      fno   = exp_fcnt;
      drops = 0;
      for (int c = 0; c < 64; c++) begin
         case (mode)
            0:       fd_tab[c] = '1;
            1:       fd_tab[c] = (c == 0) ? '0 : N_LANES'(1 << ((c - 1) % N_LANES));
            default: fd_tab[c] = N_LANES'($urandom);
         endcase
      end

      if (in_full(1, full_lo, full_hi)) drops++;
      else expect_word(1, {4'h8, fno}, rst_at);

      for (int w = 0; w < NW; w++) begin
         acc = '0;
         for (int s = 0; s < K; s++) acc = (acc << N_LANES) | 32'(fd_tab[1 + w * K + s]);
         c_w = 1 + (w + 1) * K;
         if (in_full(c_w, full_lo, full_hi)) drops++;
         else expect_word(c_w, {4'h0, acc}, rst_at);
      end

      trl_cyc = FRAME_BITS + 2;
      while (in_full(trl_cyc, full_lo, full_hi)) trl_cyc++;
      ign = (xstart >= 1) && (xstart < trl_cyc);
      expect_word(trl_cyc, {2'b11, drops != 0, ign, fno[15:0], 16'(drops)}, rst_at);

      last = (rst_at > 0) ? rst_at + 1 : trl_cyc;
      for (int c = 0; c <= last; c++) begin
         cur_cyc       = c;
         bus.start     = (c == 0) || (c == xstart);
         bus.fd        = fd_tab[c];
         bus.fifo_full = in_full(c, full_lo, full_hi);
         rst           = (rst_at > 0) && (c == rst_at);
         @(negedge clk);
         if (rst_at > 0 && c == rst_at + 1) begin
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
            check("rst_data_out", 64'(bus.data_out), 64'd0);
            check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
            check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
         end else begin
            check("busy", 64'(bus.busy),
                  64'((c >= 1) && (c <= trl_cyc) && (rst_at == 0 || c <= rst_at)));
         end
         @(posedge clk);
         #1;
      end

      bus.start     = 1'b0;
      bus.fifo_full = 1'b0;
      rst           = 1'b0;
      if (rst_at > 0) begin
         exp_fcnt = '0;
         exp_dcnt = '0;
      end else begin
         exp_fcnt = fno + 32'd1;
         exp_dcnt = exp_dcnt + CNT_WIDTH'(drops);
      end
      check("frame_cnt", 64'(bus.frame_cnt), 64'(exp_fcnt));
      check("drop_cnt", 64'(bus.drop_cnt), 64'(exp_dcnt));
      check("missing_writes", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.fd        = '0;
      bus.fifo_full = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("init_busy", 64'(bus.busy), 64'd0);
      check("init_wr_en", 64'(bus.fifo_wr_en), 64'd0);
      check("init_data_out", 64'(bus.data_out), 64'd0);
      check("init_frame_cnt", 64'(bus.frame_cnt), 64'd0);
      check("init_drop_cnt", 64'(bus.drop_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_frame(0, -1, -1, 0, 0);   // nominal, all ones
      run_frame(2, -1, -1, 0, 0);   // back-to-back, header 1
      run_frame(1, -1, -1, 0, 0);   // lane ordering
      run_frame(2,  9,  9, 0, 0);   // data word dropped
      run_frame(2,  1,  1, 0, 0);   // header dropped
      run_frame(2, 17, 20, 0, 0);   // trailer backpressure
      run_frame(2, -1, -1, 7, 0);   // start while busy
      run_frame(2,  5, 13, 3, 0);   // several drops plus ignored start
      run_frame(2, -1, -1, 0, 10);  // reset mid-frame
      run_frame(0, -1, -1, 0, 0);   // first frame after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the end of the test");
      $fatal(1);
   end

endmodule
